uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
//
// PURPOSE
//  Byte FIFO that sits directly upstream of the UART transmitter and drains into its tx_enable/tx_data/tx_busy handshake.
//  Producers push bytes at clock rate; the block paces them out one byte per transmitter frame.
//  A byte is handed to the transmitter by a one-cycle tx_enable pulse.
//
// PARAMETERS
//  DEPTH  16  FIFO capacity in bytes; power of two, >= 2.
//  AW     4   Pointer width, log2(DEPTH); must match DEPTH.
//
// PORTS
//  clk        in   1     System clock.
//  resetn     in   1     Asynchronous active-low reset.
//  wr_en      in   1     Push request; wr_data is sampled when wr_en=1.
//  wr_data    in   8     Byte to enqueue.
//  flush      in   1     Synchronous clear of FIFO contents and overflow.
//  full       out  1     level == DEPTH.
//  empty      out  1     level == 0.
//  level      out  AW+1  Bytes currently stored, 0..DEPTH.
//  overflow   out  1     Sticky; set when a push is dropped.
//  tx_busy    in   1     Transmitter busy; high from the cycle after acceptance until the frame ends.
//  tx_enable  out  1     Registered one-cycle pulse; presents tx_data to the transmitter.
//  tx_data    out  8     Registered byte under transfer; holds its last value otherwise.
//
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - Pointers, level, overflow and tx_enable clear to 0.
//   - tx_data clears to 8'h00; FSM goes to IDLE; empty=1, full=0.
//   - A reset mid-frame abandons all stored bytes. The transmitter's own reset handles the line.
//  Storage:
//   - Circular buffer with AW-bit read and write pointers that wrap DEPTH-1 -> 0.
//   - level is a separate AW+1-bit counter.
//  Push:
//   - When wr_en=1 and full=0, write mem[wptr], increment wptr, and increment level.
//   - When wr_en=1 and full=1, drop the byte, set overflow=1, and leave state unchanged. This holds even if a pop happens in the same cycle.
//  Pop:
//   - Happens only on the FSM IDLE->SEND transition.
//   - tx_data <= mem[rptr]; rptr increments; level decrements.
//  Push and pop in the same cycle (not full): level is unchanged and both pointers advance.
//  Push to an empty FIFO: the byte is eligible for pop on the next cycle. There is no fall-through within a cycle.
//  FSM states:
//   - IDLE: when empty=0 and tx_busy=0, pop, set tx_enable<=1, and go to SEND. Otherwise stay.
//   - SEND: tx_enable=1 for exactly this cycle; next state is GAP. tx_enable<=0.
//   - GAP: wait one cycle so tx_busy can rise, then go to IDLE. IDLE waits for tx_busy=0 before the next pop.
//  Timing:
//   - Minimum spacing between tx_enable pulses is 3 cycles; in practice it is one UART frame.
//   - Latency from the first push into an idle, empty FIFO to tx_enable=1 is 2 cycles.
//  flush:
//   - Has priority over a simultaneous push.
//   - Sets rptr=wptr=0, level=0, overflow=0.
//   - Does not cancel a byte already in SEND or GAP, or one the transmitter has accepted. The FSM completes to IDLE normally.
//   - The next push after flush lands at address 0.
//  tx_data is stable whenever tx_enable=1.
//  overflow clears only on flush or reset.
//
// TESTING
//  1. Push 8'h41, 8'h42, 8'h43 back-to-back with tx_busy modelled as 10 cycles per byte.
//     -> Three tx_enable pulses carry 41, 42, 43 in order, spaced >= 10 cycles; empty=1 at end.
//  2. Push 17 bytes (0x00..0x10) while tx_busy is held at 1.
//     -> full=1 and level=16 after 16 pushes; 0x10 is dropped and overflow=1.
//     -> After releasing tx_busy, exactly 0x00..0x0F are sent.
//  3. With the FIFO full and FSM in IDLE, release tx_busy and push 8'hAA in the pop cycle.
//     -> AA is dropped, overflow=1, and level goes 16 -> 15.
//  4. Push 20 bytes in two bursts so the pointers wrap past DEPTH-1.
//     -> Output order matches input order and level never exceeds 16.
//  5. Assert flush during GAP with level=5.
//     -> The in-flight byte completes, level=0, empty=1, overflow=0, and no further tx_enable pulses occur.
//  6. Deassert resetn mid-frame with level=7.
//     -> tx_enable=0, tx_data=00, level=0 and empty=1 immediately, without waiting for clk.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer push/status signals and transmitter handshake of the tx byte FIFO
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;
  logic        tx_busy;
  logic        tx_enable;
  logic [7:0]  tx_data;
  modport master (
    output wr_en, wr_data, flush, tx_busy,
    input  full, empty, level, overflow, tx_enable, tx_data
  );
  modport slave (
    input  wr_en, wr_data, flush, tx_busy,
    output full, empty, level, overflow, tx_enable, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO pacing bytes into the UART transmitter, one tx_enable pulse per frame
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic           clk,
  input logic           resetn,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;
  logic          overflow, full, empty, push, pop;
  assign full          = level == (AW+1)'(DEPTH);
  assign empty         = level == '0;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.level     = level;
  assign bus.overflow  = overflow;
  // flush wins over both a push and a fresh pop in the same cycle
  assign push = bus.wr_en && !full && !bus.flush;
  assign pop  = state == IDLE && !empty && !bus.tx_busy && !bus.flush;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= bus.wr_data;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (bus.flush) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (bus.wr_en && full) overflow <= 1'b1;
    end
  // GAP gives the transmitter one cycle to raise tx_busy before IDLE looks at it
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state         <= IDLE;
      bus.tx_enable <= 1'b0;
      bus.tx_data   <= 8'h00;
    end else begin
      case (state)
        IDLE: if (pop) begin
          state         <= SEND;
          bus.tx_enable <= 1'b1;
          bus.tx_data   <= mem[rptr];
        end
        SEND: begin
          state         <= GAP;
          bus.tx_enable <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized scenarios checked against a queue model of the byte FIFO
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  logic clk = 0;
  logic resetn = 0;
  logic hold = 0;
  int   frame = 10;
  int   busy_cnt;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [7:0] mq[$];
  logic [7:0] sent_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  logic       exp_ovf = 0;
  uart_tx_fifo_if #(.AW(AW)) bus ();
  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  // transmitter stand-in: busy from the cycle after acceptance for frame cycles
  always @(posedge clk or negedge resetn)
    if (!resetn) busy_cnt <= 0;
    else if (bus.tx_enable) busy_cnt <= frame;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  assign bus.tx_busy = hold || busy_cnt != 0;

  task automatic step(input logic we, input logic [7:0] d, input logic fl);
    int pre;
    pre = mq.size();
    bus.wr_en = we;
    bus.wr_data = d;
    bus.flush = fl;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.tx_enable) begin
      got_q.push_back(bus.tx_data);
      got_t.push_back(cyc);
    end
    if (fl) begin
      mq.delete();
      exp_ovf = 0;
    end else begin
      if (bus.tx_enable && mq.size() > 0) sent_q.push_back(mq.pop_front());
      if (we) begin
        if (pre < DEPTH) mq.push_back(d);
        else exp_ovf = 1;
      end
    end
    bus.wr_en = 0;
    bus.flush = 0;
  endtask

  task automatic drain(output bit to);
    int n = 0;
    while (mq.size() != 0 && n < 4000) begin
      step(0, 8'h00, 0);
      n++;
    end
    repeat (40) step(0, 8'h00, 0);
    to = mq.size() != 0;
  endtask

  task automatic clear_logs();
    sent_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  task automatic test_reset();
    checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.tx_enable !== 1'b0) begin failures++; $display("FAIL reset_tx_enable got=%b exp=0", bus.tx_enable); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
  endtask

  task automatic test_basic();
    bit to;
    frame = 10;
    step(0, 8'h00, 1);
    clear_logs();
    step(1, 8'h41, 0);
    checks++; if (bus.tx_enable !== 1'b0) begin failures++; $display("FAIL basic_early_pulse got=%b exp=0", bus.tx_enable); end
    step(1, 8'h42, 0);
    checks++; if (bus.tx_enable !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", bus.tx_enable); end
    step(1, 8'h43, 0);
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL basic_drain_timeout left=%0d exp=0", mq.size()); end
    checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'(8'h41 + i)) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got_q[i], 8'(8'h41 + i)); end
    end
    for (int i = 1; i < got_t.size(); i++) begin
      checks++; if (got_t[i] - got_t[i-1] < 10) begin failures++; $display("FAIL basic_spacing[%0d] got=%0d exp>=10", i, got_t[i] - got_t[i-1]); end
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_overflow();
    bit to;
    step(0, 8'h00, 1);
    clear_logs();
    hold = 1;
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", bus.full); end
    checks++; if (bus.level !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", bus.level); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", bus.overflow); end
    step(1, 8'h10, 0);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    checks++; if (bus.level !== 5'd16) begin failures++; $display("FAIL ovf_level_after_drop got=%0d exp=16", bus.level); end
    hold = 0;
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL ovf_drain_timeout left=%0d exp=0", mq.size()); end
    checks++; if (got_q.size() !== 16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'(i)) begin failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, got_q[i], 8'(i)); end
    end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_persist got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_pop_collision();
    bit to;
    step(0, 8'h00, 1);
    clear_logs();
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL coll_flush_ovf got=%b exp=0", bus.overflow); end
    hold = 1;
    for (int i = 0; i < 16; i++) step(1, 8'($urandom_range(0, 8'h9F)), 0);
    hold = 0;
    step(1, 8'hAA, 0);
    checks++; if (bus.tx_enable !== 1'b1) begin failures++; $display("FAIL coll_pop got=%b exp=1", bus.tx_enable); end
    checks++; if (bus.level !== 5'd15) begin failures++; $display("FAIL coll_level got=%0d exp=15", bus.level); end
    checks++; if (bus.overflow !== exp_ovf) begin failures++; $display("FAIL coll_overflow got=%b exp=%b", bus.overflow, exp_ovf); end
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL coll_drain_timeout left=%0d exp=0", mq.size()); end
    checks++; if (got_q.size() !== sent_q.size()) begin failures++; $display("FAIL coll_count got=%0d exp=%0d", got_q.size(), sent_q.size()); end
    for (int i = 0; i < sent_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== sent_q[i]) begin failures++; $display("FAIL coll_data[%0d] got=%h exp=%h", i, got_q[i], sent_q[i]); end
    end
  endtask

  task automatic test_wrap();
    bit to;
    frame = $urandom_range(3, 6);
    clear_logs();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < (b == 0 ? 12 : 8); i++) begin
        step(1, 8'($urandom), 0);
        checks++; if (bus.level !== 5'(mq.size()) || bus.level > 5'd16) begin failures++; $display("FAIL wrap_level got=%0d exp=%0d", bus.level, mq.size()); end
      end
      repeat (10) step(0, 8'h00, 0);
    end
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL wrap_drain_timeout left=%0d exp=0", mq.size()); end
    checks++; if (got_q.size() !== sent_q.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), sent_q.size()); end
    for (int i = 0; i < sent_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== sent_q[i]) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, got_q[i], sent_q[i]); end
    end
    for (int i = 1; i < got_t.size(); i++) begin
      checks++; if (got_t[i] - got_t[i-1] < 3) begin failures++; $display("FAIL wrap_spacing[%0d] got=%0d exp>=3", i, got_t[i] - got_t[i-1]); end
    end
  endtask

  task automatic test_flush();
    frame = 10;
    step(0, 8'h00, 1);
    clear_logs();
    hold = 1;
    for (int i = 0; i < 6; i++) step(1, 8'($urandom), 0);
    hold = 0;
    step(0, 8'h00, 0);
    checks++; if (bus.tx_enable !== 1'b1) begin failures++; $display("FAIL flush_send got=%b exp=1", bus.tx_enable); end
    step(0, 8'h00, 0);
    checks++; if (bus.level !== 5'd5) begin failures++; $display("FAIL flush_pre_level got=%0d exp=5", bus.level); end
    step(1, 8'h77, 1);
    checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", bus.level); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL flush_overflow got=%b exp=0", bus.overflow); end
    repeat (40) step(0, 8'h00, 0);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL flush_pulses got=%0d exp=1", got_q.size()); end
    checks++; if (got_q.size() > 0 && got_q[0] !== sent_q[0]) begin failures++; $display("FAIL flush_inflight got=%h exp=%h", got_q[0], sent_q[0]); end
  endtask

  task automatic test_reset_mid();
    step(0, 8'h00, 1);
    clear_logs();
    hold = 1;
    for (int i = 0; i < 8; i++) step(1, 8'($urandom_range(8'h80, 8'hFF)), 0);
    hold = 0;
    step(0, 8'h00, 0);
    checks++; if (bus.level !== 5'd7) begin failures++; $display("FAIL rst_pre_level got=%0d exp=7", bus.level); end
    resetn = 0;
    #2;
    checks++; if (bus.tx_enable !== 1'b0) begin failures++; $display("FAIL rst_tx_enable got=%b exp=0", bus.tx_enable); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", bus.tx_data); end
    checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", bus.level); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", bus.empty); end
    mq.delete();
    exp_ovf = 0;
    #2;
    resetn = 1;
    clear_logs();
    repeat (30) step(0, 8'h00, 0);
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL rst_pulses got=%0d exp=0", got_q.size()); end
  endtask

  initial begin
    bus.wr_en = 0;
    bus.wr_data = 0;
    bus.flush = 0;
    #12;
    test_reset();
    resetn = 1;
    test_basic();
    test_overflow();
    test_pop_collision();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
